// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types and word-format helpers for the DAC datapath stages
package dac_pkg;

  // Widest output word the helpers can build; callers truncate to their own width.
  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } feed_state_e;

  // Unsigned midscale code (only the MSB set) for a data_size-bit modulator word.
  function automatic logic [MAX_W-1:0] midscale(input int unsigned data_size);
    return MAX_W'(1) << (data_size - 1);
  endfunction

  // Two's complement in_size-bit sample to offset binary, left-justified in data_size bits.
  function automatic logic [MAX_W-1:0] offset_lj(input logic [MAX_W-1:0] s,
                                                  input int unsigned      in_size,
                                                  input int unsigned      data_size);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << in_size) - MAX_W'(1);
    return ((s ^ (MAX_W'(1) << (in_size - 1))) & mask) << (data_size - in_size);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - show-ahead synchronous FIFO with registered level, DEPTH a power of two >= 2
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  // Full/empty come only from the registered level, so a full FIFO refuses a push even while popping.
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Next-state: write slot, pointer advance and occupancy bookkeeping.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // State registers; storage is not cleared on reset, only the pointers and level.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/dac_sample_feeder.sv
// rtl/dac_sample_feeder.sv - PCM input FIFO, linear interpolator and offset-binary word driver for the delta-sigma modulator
module dac_sample_feeder
  import dac_pkg::*;
#(
  parameter int DATA_SIZE   = 32,
  parameter int IN_SIZE     = 16,
  parameter int INTERP_LOG2 = 2,
  parameter int HOLD_CYCLES = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [IN_SIZE-1:0]             in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DATA_SIZE-1:0]           out_data,
  output logic                           out_strobe,
  output logic                           underrun,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int ACC_W = IN_SIZE + INTERP_LOG2 + 1;
  localparam int DLT_W = IN_SIZE + 1;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [INTERP_LOG2-1:0] K_MAX    = '1;
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [DATA_SIZE-1:0]   MID      = DATA_SIZE'(midscale(DATA_SIZE));

  // Two's complement values held in plain vectors; sign extension is explicit below.
  feed_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IN_SIZE-1:0]     prev_q, prev_d;
  logic [IN_SIZE-1:0]     cur_q, cur_d;
  logic [DLT_W-1:0]       delta_q, delta_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [INTERP_LOG2-1:0] k_q, k_d;
  logic [DATA_SIZE-1:0]   out_data_q, out_data_d;
  logic                   out_strobe_q, out_strobe_d;
  logic                   underrun_q, underrun_d;

  logic [IN_SIZE-1:0]     fifo_rdata;
  logic                   fifo_full, fifo_empty, fifo_pop;
  logic                   tick, seg_end, use_mid;
  logic [IN_SIZE-1:0]     s_sel;
  logic signed [ACC_W-1:0] acc_step;

  // Segment start point: sample scaled by the interpolation factor, one guard bit above.
  function automatic logic [ACC_W-1:0] acc_load(input logic [IN_SIZE-1:0] x);
    return {x[IN_SIZE-1], x, {INTERP_LOG2{1'b0}}};
  endfunction

  // Sign-extended difference so a full-scale swing (e.g. 0x7FFF -> 0x8000) does not wrap.
  function automatic logic [DLT_W-1:0] seg_delta(input logic [IN_SIZE-1:0] to_s,
                                                  input logic [IN_SIZE-1:0] from_s);
    return {to_s[IN_SIZE-1], to_s} - {from_s[IN_SIZE-1], from_s};
  endfunction

  sample_fifo #(
    .WIDTH (IN_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tick       = (cnt_q == CNT_LAST);
  assign acc_step   = acc_q + {{INTERP_LOG2{delta_q[DLT_W-1]}}, delta_q};
  assign in_ready   = !fifo_full;
  assign out_data   = out_data_q;
  assign out_strobe = out_strobe_q;
  assign underrun   = underrun_q;

  // Tick counter plus the interpolator step / segment-boundary decisions taken on each tick.
  always_comb begin
    state_d      = state_q;
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    prev_d       = prev_q;
    cur_d        = cur_q;
    delta_d      = delta_q;
    acc_d        = acc_q;
    k_d          = k_q;
    out_data_d   = out_data_q;
    out_strobe_d = 1'b0;
    underrun_d   = 1'b0;
    fifo_pop     = 1'b0;
    seg_end      = 1'b0;
    use_mid      = 1'b0;
    s_sel        = cur_q;
    if (tick) begin
      out_strobe_d = 1'b1;
      unique case (state_q)
        ST_EMPTY: begin
          if (fifo_empty) begin
            use_mid = 1'b1;
          end else begin
            fifo_pop = 1'b1;
            prev_d   = fifo_rdata;
            cur_d    = fifo_rdata;
            delta_d  = '0;
            acc_d    = acc_load(fifo_rdata);
            k_d      = '0;
            s_sel    = fifo_rdata;
            state_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          if (k_q != K_MAX) begin
            acc_d = acc_step;
            k_d   = k_q + 1'b1;
            s_sel = IN_SIZE'(acc_step >>> INTERP_LOG2);
          end else begin
            seg_end = 1'b1;
          end
        end
        default: seg_end = 1'b1;
      endcase
      // New segment always starts from the old endpoint; with no next sample it flattens out.
      if (seg_end) begin
        s_sel  = cur_q;
        prev_d = cur_q;
        acc_d  = acc_load(cur_q);
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_rdata;
          delta_d  = seg_delta(fifo_rdata, cur_q);
          k_d      = '0;
          state_d  = ST_RUN;
        end else begin
          delta_d    = '0;
          underrun_d = (state_q == ST_RUN);
          state_d    = ST_HOLD;
        end
      end
      out_data_d = use_mid ? MID
                           : DATA_SIZE'(offset_lj(MAX_W'(s_sel), IN_SIZE, DATA_SIZE));
    end
  end

  // Single state register bank; reset forces midscale and EMPTY regardless of position.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_EMPTY;
      cnt_q        <= '0;
      prev_q       <= '0;
      cur_q        <= '0;
      delta_q      <= '0;
      acc_q        <= '0;
      k_q          <= '0;
      out_data_q   <= MID;
      out_strobe_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      cur_q        <= cur_d;
      delta_q      <= delta_d;
      acc_q        <= acc_d;
      k_q          <= k_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb/tb_dac_sample_feeder.sv - self-checking bench for dac_sample_feeder
module tb_dac_sample_feeder;

  localparam int DATA_SIZE   = 32;
  localparam int IN_SIZE     = 16;
  localparam int INTERP_LOG2 = 2;
  localparam int HOLD_CYCLES = 4;
  localparam int FIFO_DEPTH  = 4;
  localparam int NSTEP       = 1 << INTERP_LOG2;
  localparam logic [31:0] MID = 32'h8000_0000;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [IN_SIZE-1:0]    in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_SIZE-1:0]  out_data;
  logic                  out_strobe;
  logic                  underrun;
  logic [2:0]            fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_sample_feeder #(
    .DATA_SIZE   (DATA_SIZE),
    .IN_SIZE     (IN_SIZE),
    .INTERP_LOG2 (INTERP_LOG2),
    .HOLD_CYCLES (HOLD_CYCLES),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] head;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] r3;
    logic [31:0] hold;
  } vec_t;

  vec_t vecs [4];

  // reference model: sample queue plus segment endpoints a -> b and step j
  int          mq [$];
  int          m_phase;
  int          m_a, m_b, m_j, m_cnt;
  logic [31:0] m_out;
  logic        m_strobe, m_under;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp_v);
    end
  endtask

  function automatic logic [31:0] off(input int s);
    logic [31:0] u;
    u = 32'(s + 32768);
    return u << 16;
  endfunction

  function automatic int floor_div(input int x, input int n);
    return (x >= 0) ? x / n : -((-x + n - 1) / n);
  endfunction

  function automatic int interp(input int a, input int b, input int j);
    return floor_div(a * NSTEP + j * (b - a), NSTEP);
  endfunction

  function automatic void model_edge(input logic r, input logic v, input logic [15:0] d);
    bit tick, accept;
    if (!r) begin
      mq.delete();
      m_phase = 0; m_cnt = 0; m_j = 0; m_a = 0; m_b = 0;
      m_out = MID; m_strobe = 1'b0; m_under = 1'b0;
      return;
    end
    tick   = (m_cnt == HOLD_CYCLES - 1);
    accept = v && (mq.size() < FIFO_DEPTH);
    m_strobe = tick;
    m_under  = 1'b0;
    if (tick) begin
      if (m_phase == 0) begin
        if (mq.size() > 0) begin
          m_a = mq.pop_front(); m_b = m_a; m_j = 0;
          m_out = off(m_a); m_phase = 1;
        end else begin
          m_out = MID;
        end
      end else if (m_phase == 1 && m_j < NSTEP - 1) begin
        m_j++;
        m_out = off(interp(m_a, m_b, m_j));
      end else begin
        m_out = off(m_b);
        m_a = m_b;
        if (mq.size() > 0) begin
          m_b = mq.pop_front(); m_j = 0; m_phase = 1;
        end else begin
          if (m_phase == 1) m_under = 1'b1;
          m_phase = 2;
        end
      end
    end
    if (accept) mq.push_back(int'($signed(d)));
    m_cnt = (m_cnt + 1) % HOLD_CYCLES;
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [15:0] d);
    reset = r; in_valid = v; in_data = d;
    model_edge(r, v, d);
    @(posedge clk);
    @(negedge clk);
    chk("rnd_out_data", out_data, m_out);
    chk("rnd_strobe", 32'(out_strobe), 32'(m_strobe));
    chk("rnd_underrun", 32'(underrun), 32'(m_under));
    chk("rnd_level", 32'(fifo_level), 32'(mq.size()));
    chk("rnd_in_ready", 32'(in_ready), 32'(mq.size() < FIFO_DEPTH));
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_strobe) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1; in_data = a;
    @(negedge clk);
    in_data = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    bit          ok;
    int          acc;
    logic [31:0] exp_w;
    logic [31:0] resume [4];

    reset = 1'b0; in_valid = 1'b0; in_data = '0;

    vecs[0] = '{16'h0000, 16'h0400, 32'h8000_0000, 32'h8100_0000, 32'h8200_0000, 32'h8300_0000, 32'h8400_0000};
    vecs[1] = '{16'h7FFF, 16'h8000, 32'hFFFF_0000, 32'hBFFF_0000, 32'h7FFF_0000, 32'h3FFF_0000, 32'h0000_0000};
    vecs[2] = '{16'h8000, 16'h7FFF, 32'h0000_0000, 32'h3FFF_0000, 32'h7FFF_0000, 32'hBFFF_0000, 32'hFFFF_0000};
    vecs[3] = '{16'h0001, 16'hFFFE, 32'h8001_0000, 32'h8000_0000, 32'h7FFF_0000, 32'h7FFE_0000, 32'h7FFE_0000};
    resume  = '{32'h8400_0000, 32'h8300_0000, 32'h8200_0000, 32'h8100_0000};

    // reset values and idle strobe cadence
    do_reset();
    chk("rst_out_data", out_data, MID);
    chk("rst_strobe", 32'(out_strobe), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk($sformatf("idle_strobe_e%0d", i), 32'(out_strobe), 32'(i % 4 == 0));
      chk($sformatf("idle_out_e%0d", i), out_data, MID);
    end

    // table: push a then b, check nine tick outputs ending in the underrun hold
    for (int v = 0; v < 4; v++) begin
      do_reset();
      push_pair(vecs[v].a, vecs[v].b);
      for (int t = 0; t < 9; t++) begin
        wait_strobe(ok);
        chk($sformatf("vec%0d_strobe%0d", v, t), 32'(ok), 32'd1);
        case (t)
          5:       exp_w = vecs[v].r1;
          6:       exp_w = vecs[v].r2;
          7:       exp_w = vecs[v].r3;
          8:       exp_w = vecs[v].hold;
          default: exp_w = vecs[v].head;
        endcase
        chk($sformatf("vec%0d_tick%0d", v, t), out_data, exp_w);
        chk($sformatf("vec%0d_under%0d", v, t), 32'(underrun), 32'(t == 8));
      end
      @(negedge clk);
      chk($sformatf("vec%0d_under_pulse", v), 32'(underrun), 32'd0);
    end

    // underrun then resume with a falling ramp back to zero
    do_reset();
    push_pair(16'h0000, 16'h0400);
    for (int t = 0; t < 9; t++) wait_strobe(ok);
    chk("ur_hold_out", out_data, 32'h8400_0000);
    chk("ur_pulse", 32'(underrun), 32'd1);
    in_valid = 1'b1; in_data = 16'h0000;
    @(negedge clk);
    in_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      wait_strobe(ok);
      chk($sformatf("ur_resume_strobe%0d", t), 32'(ok), 32'd1);
      chk($sformatf("ur_resume_out%0d", t), out_data, resume[t]);
      chk($sformatf("ur_resume_under%0d", t), 32'(underrun), 32'd0);
    end

    // full FIFO: continuous in_valid; only the first-tick pop frees a slot before edge 20
    do_reset();
    in_valid = 1'b1;
    acc = 0;
    for (int c = 1; c <= 19; c++) begin
      in_data = 16'(c);
      if (in_ready) acc++;
      @(negedge clk);
    end
    chk("full_accepted", 32'(acc), 32'd5);
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("full_after_pop_level", 32'(fifo_level), 32'd3);
    chk("full_after_pop_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("full_refill_level", 32'(fifo_level), 32'd4);
    in_valid = 1'b0;

    // reset in the middle of a segment (k = 2)
    do_reset();
    push_pair(16'h0000, 16'h0400);
    for (int t = 0; t < 3; t++) wait_strobe(ok);
    chk("mid_pre_level", 32'(fifo_level), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out", out_data, MID);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_strobe", 32'(out_strobe), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("mid_rel_strobe_e%0d", i), 32'(out_strobe), 32'(i == 4));
    end
    chk("mid_rel_out", out_data, MID);

    // randomized traffic against the reference model, alternating heavy and light load
    cyc(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 800; i++) begin
      int          pct;
      logic        r, v;
      logic [15:0] d;
      pct = ((i / 100) % 2 == 0) ? 80 : 15;
      r = ($urandom_range(0, 249) != 0);
      v = ($urandom_range(0, 99) < pct);
      case ($urandom_range(0, 3))
        0:       d = 16'h7FFF;
        1:       d = 16'h8000;
        default: d = 16'($urandom);
      endcase
      cyc(r, v, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_sample_feeder.md
# dac_sample_feeder

Upstream stage of the delta-sigma DAC. It accepts signed PCM samples through a valid/ready handshake and buffers them in a small FIFO. It linearly interpolates between consecutive samples and drives the modulator's unsigned `data` input with a left-justified offset-binary word. That word is updated once every `HOLD_CYCLES` clocks, so the modulator sees a stable input for each of its conversion frames.

## Interface
- `DATA_SIZE`, 32: output width; equals the modulator's `DATA_SIZE`; must be ≥ `IN_SIZE`.
- `IN_SIZE`, 16: input sample width, two's complement.
- `INTERP_LOG2`, 2: interpolation factor is 2^`INTERP_LOG2` output updates per input sample.
- `HOLD_CYCLES`, 32: clocks between output updates (ticks).
- `FIFO_DEPTH`, 4: input FIFO entries, power of two.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: **synchronous, active-low**; sampled on `clk`.
- `in_data` in `IN_SIZE`: signed input sample.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: FIFO not full; a push happens when `in_valid && in_ready` at a clock edge.
- `out_data` out `DATA_SIZE`: unsigned sample to the modulator.
- `out_strobe` out 1: one-cycle pulse in the cycle `out_data` takes a new value.
- `underrun` out 1: one-cycle pulse when a segment boundary finds the FIFO empty in RUN.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- **Tick counter.** Counts 0..`HOLD_CYCLES`-1 and wraps. A tick occurs in the cycle the count equals `HOLD_CYCLES`-1.
- **Tick action.** On each tick the interpolator advances one step, `out_data` is updated, and `out_strobe` is asserted.
- **Registers:** `prev`, `cur` (`IN_SIZE` signed), `delta` = `cur`-`prev` (`IN_SIZE`+1 signed), `acc` (`IN_SIZE`+`INTERP_LOG2`+1 signed), step index `k` (`INTERP_LOG2` bits).
- **Output word.** `s` = `acc >>> INTERP_LOG2` (arithmetic, floor). `out_data` = {~s[MSB], s[MSB-1:0]} << (`DATA_SIZE`-`IN_SIZE`).
- **EMPTY** (state after reset):
  - Each tick outputs midscale, 1 << (`DATA_SIZE`-1).
  - On a tick with FIFO non-empty: pop into `cur` and `prev`, set `delta`=0, `acc`=`cur`<<`INTERP_LOG2`, `k`=0, output `s`=`cur`, go to RUN.
- **RUN:**
  - Tick with `k` < max: `acc` += `delta`, `k`++, output from the new `acc`.
  - Tick with `k` = max (segment boundary), FIFO non-empty: `prev`←`cur`, `cur`←pop, `delta`←pop−`cur`, `acc`←`cur`<<`INTERP_LOG2`, `k`←0. The output is the old `cur`, i.e. the first point of the new segment.
  - Tick with `k` = max, FIFO empty: `prev`←`cur`, `delta`←0, `acc`←`cur`<<`INTERP_LOG2`, output the old `cur`, pulse `underrun`, go to HOLD.
- **HOLD:**
  - Each tick re-outputs `cur`.
  - On a tick with FIFO non-empty, run the segment-boundary load above with no `underrun` pulse, then return to RUN.
- **Width rule.** `delta` is computed from sign-extended operands. The full-scale step from 0x7FFF to 0x8000 (−65535) must not wrap.

## Timing
- **Reset values:** `out_data` = midscale, `out_strobe`=0, `underrun`=0, `in_ready`=1, `fifo_level`=0, state EMPTY, tick count 0, FIFO emptied.
- **First tick** occurs on the `HOLD_CYCLES`-th edge after `reset` goes high.
- **Push and pop timing.** A pushed sample is poppable from the next cycle. `fifo_level` updates one edge after a push or pop.
- **`in_ready`** is derived only from the registered level (`fifo_level` ≠ `FIFO_DEPTH`). When the FIFO is full, a push is refused even in a cycle that pops.
- **Simultaneous push and pop** when not full: level unchanged; both succeed.
- **`out_data` stability.** `out_data` is registered and changes only in the cycle `out_strobe` is high. It is stable for `HOLD_CYCLES` clocks.
- **Interpolation latency.** A sample reaches `out_data` as a segment start one boundary after it is popped.
- **Mid-operation reset.** `reset` low on any edge forces all reset values on that edge, regardless of state or `k`.

## Structure
- **Shared package `dac_pkg`:** state enum (EMPTY, RUN, HOLD), a midscale function of `DATA_SIZE`, and a signed-to-offset-binary left-justify function reused by other DAC stages.
- **Sub-module `sample_fifo`:** synchronous FIFO with push, pop, level, full and empty signals; the feeder instantiates one.

## Test plan
All scenarios use `IN_SIZE`=16, `DATA_SIZE`=32, `INTERP_LOG2`=2, `HOLD_CYCLES`=4, `FIFO_DEPTH`=4.
- **Reset:** release `reset`, push nothing → `out_data`=0x80000000, `in_ready`=1, `out_strobe` on the 4th edge and every 4 thereafter, `out_data` unchanged.
- **Rising ramp:** push 0x0000 then 0x0400 → ticks show 0x80000000 ×4, then 0x80000000, 0x81000000, 0x82000000, 0x83000000.
- **Extreme step:** push 0x7FFF then 0x8000 → after the 0x7FFF segment, outputs 0xFFFF0000, 0xBFFF0000, 0x7FFF0000, 0x3FFF0000 (floor), with no wrap.
- **Full FIFO:** hold `in_valid` high with no pops → exactly 4 accepted, `in_ready`=0, `fifo_level`=4. The 5th sample is accepted only on the edge after a pop lowers the level.
- **Underrun:** push one ramp pair, then stop → at the boundary `underrun` pulses once, `out_data` holds 0x84000000. Then push 0x0000 → output ramps 0x84000000, 0x83000000, 0x82000000, 0x81000000.
- **Mid-segment reset:** drive `reset` low for one cycle at `k`=2 in RUN → on that edge `out_data`=0x80000000, `fifo_level`=0, state EMPTY; the next strobe comes 4 edges after release.
